// File: rtl/ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_rd_arbiter
// Purpose  : Round-robin arbiter sharing one synchronous-read RAM port among
//            NREQ burst requesters. One requester is granted per arbitration
//            (IDLE) cycle. The RAM is then read for len+1 consecutive cycles
//            (BURST). The read data comes back one cycle later and is
//            re-registered as a one-hot tagged response stream.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            req_valid/addr/len  - per-requester burst requests (packed)
//            req_ready           - one-hot, combinational accept pulse
//            ram_rd_en/addr      - RAM read command
//            ram_rd_word         - RAM data, valid one cycle after ram_rd_en
//            resp_valid/word/last- response beat (one-hot valid, shared data)
//            busy                - a burst is being issued to the RAM
// Revision : 1.0 - initial release
// ============================================================================
module ram_rd_arbiter #(
    parameter int BDADDR = 12,
    parameter int BDWORD = 32*64,
    parameter int NREQ   = 4,
    parameter int BDLEN  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*BDADDR-1:0] req_addr,
    input  logic [NREQ*BDLEN-1:0]  req_len,
    output logic [NREQ-1:0]        req_ready,
    output logic                   ram_rd_en,
    output logic [BDADDR-1:0]      ram_rd_addr,
    input  logic [BDWORD-1:0]      ram_rd_word,
    output logic [NREQ-1:0]        resp_valid,
    output logic [BDWORD-1:0]      resp_word,
    output logic                   resp_last,
    output logic                   busy
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_PTR_W:0]    w_sum;
    logic [c_PTR_W:0]    w_nsum;
    logic [c_PTR_W-1:0]  w_cand;
    logic [c_PTR_W-1:0]  w_gnt_idx;
    logic [c_PTR_W-1:0]  w_ptr_next;
    logic                w_gnt_found;
    logic [NREQ-1:0]     w_gnt_oh;
    logic [BDADDR-1:0]   w_sel_addr;
    logic [BDLEN-1:0]    w_sel_len;
    logic                w_accept;
    logic                w_last_beat;

    logic [BDADDR-1:0]   r_addr;
    logic [BDLEN-1:0]    r_cnt;      // beats still to issue after the current one
    logic [NREQ-1:0]     r_gnt_oh;

    logic [NREQ-1:0]     r_p1_valid; // beat tag travelling alongside the RAM read
    logic                r_p1_last;
    logic [NREQ-1:0]     r_resp_valid;
    logic [BDWORD-1:0]   r_resp_word;
    logic                r_resp_last;

    // ------------------------------------------------------------------------
    // Round-robin search. Candidates are visited from the farthest offset back
    // to offset 0, so the last hit is the one closest to r_ptr.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_ptr_next  = r_ptr;
        w_sum       = '0;
        w_nsum      = '0;
        w_cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (c_PTR_W+1)'(k);
            if (w_sum >= (c_PTR_W+1)'(NREQ)) begin
                w_sum = w_sum - (c_PTR_W+1)'(NREQ);
            end
            w_cand = w_sum[c_PTR_W-1:0];
            if (req_valid[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
                w_nsum      = {1'b0, w_cand} + (c_PTR_W+1)'(1);
                if (w_nsum >= (c_PTR_W+1)'(NREQ)) begin
                    w_nsum = '0;
                end
                w_ptr_next  = w_nsum[c_PTR_W-1:0];
            end
        end
        w_gnt_oh = '0;
        if (w_gnt_found) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
        end
    end

    // Pick the winner's address and length out of the packed request buses.
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_sel_addr = req_addr[i*BDADDR +: BDADDR];
                w_sel_len  = req_len[i*BDLEN +: BDLEN];
            end
        end
    end

    assign w_last_beat = (r_state == S_BURST) && (r_cnt == '0);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // req_ready is gated by rst_n so it drops as soon as reset is asserted,
    // not only once the state register has been cleared.
    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rst_n && w_gnt_found) begin
                    req_ready    = w_gnt_oh;
                    w_accept     = 1'b1;
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (w_last_beat) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Burst address generator. The address is not advanced on the last beat,
    // so ram_rd_addr keeps showing the final address while idle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_gnt_oh <= '0;
        end else if (w_accept) begin
            r_ptr    <= w_ptr_next;
            r_addr   <= w_sel_addr;
            r_cnt    <= w_sel_len;
            r_gnt_oh <= w_gnt_oh;
        end else if ((r_state == S_BURST) && !w_last_beat) begin
            r_addr   <= r_addr + BDADDR'(1);
            r_cnt    <= r_cnt - BDLEN'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Response pipeline: the tag is delayed one cycle to line up with the RAM
    // data, and the data is then registered once more.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_valid   <= '0;
            r_p1_last    <= 1'b0;
            r_resp_valid <= '0;
            r_resp_last  <= 1'b0;
            r_resp_word  <= '0;
        end else begin
            r_p1_valid   <= (r_state == S_BURST) ? r_gnt_oh : '0;
            r_p1_last    <= w_last_beat;
            r_resp_valid <= r_p1_valid;
            r_resp_last  <= r_p1_last;
            if (|r_p1_valid) begin
                r_resp_word <= ram_rd_word;
            end
        end
    end

    assign ram_rd_en   = (r_state == S_BURST);
    assign busy        = (r_state == S_BURST);
    assign ram_rd_addr = r_addr;
    assign resp_valid  = r_resp_valid;
    assign resp_word   = r_resp_word;
    assign resp_last   = r_resp_last;

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rd_arbiter
// Purpose  : Self-checking bench for ram_rd_arbiter. A transaction-level model
//            schedules, for every grant, the exact cycles of each RAM read and
//            response beat. Each cycle the DUT outputs are compared with that
//            schedule. Directed bursts cover the address wrap, the
//            round-robin order, a reset mid-burst and a 256-beat burst.
//            Randomized traffic follows the directed bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rd_arbiter;

    localparam int BDADDR = 12;
    localparam int BDWORD = 64;
    localparam int NREQ   = 4;
    localparam int BDLEN  = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*BDADDR-1:0] req_addr  = '0;
    logic [NREQ*BDLEN-1:0]  req_len   = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   ram_rd_en;
    logic [BDADDR-1:0]      ram_rd_addr;
    logic [BDWORD-1:0]      ram_rd_word = '0;
    logic [NREQ-1:0]        resp_valid;
    logic [BDWORD-1:0]      resp_word;
    logic                   resp_last;
    logic                   busy;

    always #5 clk = ~clk;

    ram_rd_arbiter #(
        .BDADDR (BDADDR),
        .BDWORD (BDWORD),
        .NREQ   (NREQ),
        .BDLEN  (BDLEN)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_word (ram_rd_word),
        .resp_valid  (resp_valid),
        .resp_word   (resp_word),
        .resp_last   (resp_last),
        .busy        (busy)
    );

    // RAM contents are a fixed function of the address.
    function automatic logic [BDWORD-1:0] ram_data(input logic [BDADDR-1:0] ad);
        return {ad, 8'h5A, ~ad, 20'hC0FFE, ad};
    endfunction

    // Synchronous-read RAM. Idle cycles return noise so that any unwanted
    // capture into resp_word shows up.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_word <= ram_data(ram_rd_addr);
        else           ram_rd_word <= {$urandom, $urandom};
    end

    // ---------------------------------------------------------------- checks
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ----------------------------------------------------------------- model
    typedef struct {
        int gid;
        bit last;
        int addr;
    } beat_t;

    int                exp_rd_addr[int];   // cycle -> RAM address expected
    beat_t             exp_resp[int];      // cycle -> response beat expected
    int                m_ptr       = 0;
    int                m_burst_end = -1;   // last cycle of the current burst
    logic [BDADDR-1:0] m_addr_hold = '0;
    logic [BDWORD-1:0] m_word_hold = '0;
    int                last_grant  = -1;

    // requester-side stimulus state
    bit  v[NREQ];
    int  a[NREQ];
    int  l[NREQ];
    bit  want_rst  = 1'b1;
    bit  auto_drop = 1'b1;     // a requester withdraws once it has been granted
    bit  rec_grants = 1'b0;
    logic [NREQ-1:0] gq[$];
    int              gc[$];
    int  n_rd_en = 0;
    int  n_last  = 0;
    int  n_resp  = 0;

    task automatic run_cycle();
        logic [NREQ-1:0]   e_ready;
        logic [NREQ-1:0]   e_rv;
        logic              e_en;
        logic              e_last;
        logic [31:0]       tmp;
        int                g;
        int                len;
        int                base;
        beat_t             bt;
        @(negedge clk);
        cyc++;
        if (last_grant >= 0 && auto_drop) v[last_grant] = 1'b0;
        last_grant = -1;
        rst_n = ~want_rst;
        if (want_rst) begin
            exp_rd_addr.delete();
            exp_resp.delete();
            m_ptr       = 0;
            m_burst_end = -1;
            m_addr_hold = '0;
            m_word_hold = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            tmp = a[i];
            req_valid[i] = v[i];
            req_addr[i*BDADDR +: BDADDR] = tmp[BDADDR-1:0];
            tmp = l[i];
            req_len[i*BDLEN +: BDLEN] = tmp[BDLEN-1:0];
        end
        #1;
        // arbitration: idle once the previous burst has issued its last beat
        e_ready = '0;
        if (!want_rst && cyc > m_burst_end && (|req_valid)) begin
            g = m_ptr;
            while (!v[g]) g = (g + 1) % NREQ;
            len  = l[g];
            base = a[g];
            e_ready[g]  = 1'b1;
            last_grant  = g;
            m_ptr       = (g + 1) % NREQ;
            m_burst_end = cyc + 1 + len;
            for (int k = 0; k <= len; k++) begin
                exp_rd_addr[cyc + 1 + k] = (base + k) % (1 << BDADDR);
                exp_resp[cyc + 3 + k]    = '{gid: g, last: (k == len), addr: (base + k) % (1 << BDADDR)};
            end
        end
        e_en = exp_rd_addr.exists(cyc);
        if (e_en) begin
            tmp = exp_rd_addr[cyc];
            m_addr_hold = tmp[BDADDR-1:0];
            exp_rd_addr.delete(cyc);
        end
        e_rv   = '0;
        e_last = 1'b0;
        if (exp_resp.exists(cyc)) begin
            bt = exp_resp[cyc];
            e_rv[bt.gid] = 1'b1;
            e_last = bt.last;
            tmp = bt.addr;
            m_word_hold = ram_data(tmp[BDADDR-1:0]);
            exp_resp.delete(cyc);
        end
        check_val("req_ready",   64'(req_ready),   64'(e_ready));
        check_val("ram_rd_en",   64'(ram_rd_en),   64'(e_en));
        check_val("ram_rd_addr", 64'(ram_rd_addr), 64'(m_addr_hold));
        check_val("busy",        64'(busy),        64'(e_en));
        check_val("resp_valid",  64'(resp_valid),  64'(e_rv));
        check_val("resp_last",   64'(resp_last),   64'(e_last));
        check_val("resp_word",   resp_word,        m_word_hold);
        if (ram_rd_en)    n_rd_en++;
        if (resp_last)    n_last++;
        if (|resp_valid)  n_resp++;
        if (rec_grants && req_ready != '0) begin
            gq.push_back(req_ready);
            gc.push_back(cyc);
        end
    endtask

    task automatic reset_cycles(input int n);
        want_rst = 1'b1;
        repeat (n) run_cycle();
        want_rst = 1'b0;
    endtask

    // Present one request, wait for its grant, then let the burst drain.
    task automatic issue(input int i, input int ad, input int len);
        int  n = 0;
        bit  got = 1'b0;
        v[i] = 1'b1;
        a[i] = ad;
        l[i] = len;
        while (!got && n < 50) begin
            run_cycle();
            got = (last_grant == i);
            n++;
        end
        if (!got) check_val("grant_timeout", 64'(0), 64'(1));
        repeat (len + 6) run_cycle();
    endtask

    task automatic rand_stim();
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                if ($urandom_range(0, 15) == 0) v[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                v[i] = 1'b1;
                a[i] = int'($urandom_range(0, 4095));
                l[i] = int'($urandom_range(0, 5));
            end
        end
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        int snap_rd;
        int snap_last;
        int snap_resp;
        int n;
        int rst_left;

        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0;
            a[i] = 0;
            l[i] = 0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        reset_cycles(3);
        repeat (2) run_cycle();

        // single burst, then a burst across the top of the address space
        snap_rd = n_rd_en; snap_last = n_last;
        issue(0, 'h010, 3);
        check_val("burst0_rd_beats", 64'(n_rd_en - snap_rd), 64'(4));
        check_val("burst0_last_cnt", 64'(n_last - snap_last), 64'(1));
        issue(1, 'hFFE, 3);
        issue(2, 'h100, 1);

        // pointer now sits at 3: requesters 0 and 3 together -> 3 first, then 0
        gq.delete(); gc.delete();
        rec_grants = 1'b1;
        v[0] = 1'b1; a[0] = 'h020; l[0] = 1;
        v[3] = 1'b1; a[3] = 'h030; l[3] = 1;
        n = 0;
        while (gq.size() < 2 && n < 40) begin run_cycle(); n++; end
        rec_grants = 1'b0;
        if (gq.size() < 2) check_val("rr_timeout", 64'(gq.size()), 64'(2));
        else begin
            check_val("rr_first",  64'(gq[0]), 64'(4'b1000));
            check_val("rr_second", 64'(gq[1]), 64'(4'b0001));
        end
        repeat (8) run_cycle();

        // all four held with len 0 from a fresh pointer: grants 0,1,2,3,0 every other cycle
        reset_cycles(2);
        gq.delete(); gc.delete();
        auto_drop  = 1'b0;
        rec_grants = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1; a[i] = 'h400 + i * 16; l[i] = 0;
        end
        n = 0;
        while (gq.size() < 5 && n < 20) begin run_cycle(); n++; end
        rec_grants = 1'b0;
        auto_drop  = 1'b1;
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        if (gq.size() < 5) check_val("hold_all_timeout", 64'(gq.size()), 64'(5));
        else begin
            for (int k = 0; k < 5; k++) begin
                check_val("hold_all_grant", 64'(gq[k]), 64'(4'b0001 << (k % 4)));
                if (k > 0) check_val("hold_all_gap", 64'(gc[k] - gc[k-1]), 64'(2));
            end
        end
        repeat (8) run_cycle();

        // reset while beat 2 of an 8-beat burst is on the RAM port
        v[0] = 1'b1; a[0] = 'h200; l[0] = 7;
        n = 0;
        while (last_grant != 0 && n < 50) begin run_cycle(); n++; end
        if (n >= 50) check_val("mid_rst_grant_timeout", 64'(0), 64'(1));
        run_cycle();
        reset_cycles(2);
        snap_resp = n_resp;
        repeat (12) run_cycle();
        check_val("no_resp_after_rst", 64'(n_resp - snap_resp), 64'(0));

        // maximum length burst
        snap_rd = n_rd_en; snap_last = n_last;
        issue(0, 'h080, 255);
        check_val("long_rd_beats", 64'(n_rd_en - snap_rd), 64'(256));
        check_val("long_last_cnt", 64'(n_last - snap_last), 64'(1));

        // randomized traffic with occasional resets
        rst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            rand_stim();
            if (rst_left > 0) begin
                want_rst = 1'b1;
                rst_left--;
            end else begin
                want_rst = 1'b0;
                if ($urandom_range(0, 399) == 0) rst_left = 2;
            end
            run_cycle();
        end
        want_rst = 1'b0;
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        repeat (20) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
